// File: rtl/isp_wb_ctrl.sv
// White-balance gain controller: host offers a gain pair, gains switch only at frame boundaries.
// Define WB_GAIN_RAMP_EN to move gains toward their targets by at most RAMP_STEP per frame.
module isp_wb_ctrl #(
  parameter int GAIN_W    = 12,
  parameter int DEF_GAIN  = 256,
  parameter int RAMP_STEP = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [GAIN_W-1:0] cfg_gain_r,
  input  logic [GAIN_W-1:0] cfg_gain_b,
  input  logic              in_vsync,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_b,
  output logic              upd_done,
  output logic [7:0]        frm_cnt
);

  localparam logic [GAIN_W-1:0] DEF = GAIN_W'(DEF_GAIN);

`ifdef WB_GAIN_RAMP_EN
  typedef enum logic [1:0] {IDLE, PEND, RAMP} state_t;
  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

  // Clamped step: never passes the target, so no overshoot or wrap.
  function automatic logic [GAIN_W-1:0] stepToward(input logic [GAIN_W-1:0] cur,
                                                   input logic [GAIN_W-1:0] tgt);
    if (tgt > cur)      return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else if (cur > tgt) return ((cur - tgt) > STEP) ? cur - STEP : tgt;
    else                return cur;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, PEND} state_t;
`endif

  state_t            r_state;
  state_t            w_stateNext;
  logic              r_vsQ;
  logic [GAIN_W-1:0] r_tgtR;
  logic [GAIN_W-1:0] r_tgtB;
  logic [GAIN_W-1:0] r_gainR;
  logic [GAIN_W-1:0] r_gainB;
  logic              r_updDone;
  logic [7:0]        r_frmCnt;
  logic              w_vsRise;
  logic              w_accept;
  logic              w_apply;
  logic              w_done;
  logic [GAIN_W-1:0] w_nextR;
  logic [GAIN_W-1:0] w_nextB;

  assign w_vsRise  = in_vsync & ~r_vsQ;
  assign cfg_ready = (r_state == IDLE);
  assign w_accept  = cfg_valid & cfg_ready;
  assign gain_r    = r_gainR;
  assign gain_b    = r_gainB;
  assign upd_done  = r_updDone;
  assign frm_cnt   = r_frmCnt;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_apply     = 1'b0;
    w_done      = 1'b0;
    w_nextR     = r_gainR;
    w_nextB     = r_gainB;
    case (r_state)
      IDLE: if (w_accept) w_stateNext = PEND;
`ifdef WB_GAIN_RAMP_EN
      PEND, RAMP: if (w_vsRise) begin
        w_apply = 1'b1;
        w_nextR = stepToward(r_gainR, r_tgtR);
        w_nextB = stepToward(r_gainB, r_tgtB);
        if (w_nextR == r_tgtR && w_nextB == r_tgtB) begin
          w_done      = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_stateNext = RAMP;
        end
      end
`else
      PEND: if (w_vsRise) begin
        w_apply     = 1'b1;
        w_nextR     = r_tgtR;
        w_nextB     = r_tgtB;
        w_done      = 1'b1;
        w_stateNext = IDLE;
      end
`endif
      default: w_stateNext = IDLE;
    endcase
  end

  // A transfer on a boundary cycle only captures; application waits for the next boundary.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_vsQ     <= 1'b0;
      r_tgtR    <= DEF;
      r_tgtB    <= DEF;
      r_gainR   <= DEF;
      r_gainB   <= DEF;
      r_updDone <= 1'b0;
      r_frmCnt  <= 8'd0;
    end else begin
      r_vsQ     <= in_vsync;
      r_updDone <= w_done;
      if (w_accept) begin
        r_tgtR <= cfg_gain_r;
        r_tgtB <= cfg_gain_b;
      end
      if (w_apply) begin
        r_gainR <= w_nextR;
        r_gainB <= w_nextB;
      end
      if (w_done)
        r_frmCnt <= 8'd0;
      else if (w_vsRise && r_frmCnt != 8'hFF)
        r_frmCnt <= r_frmCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_isp_wb_ctrl.sv
// Self-checking bench for isp_wb_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_isp_wb_ctrl;

  localparam int GW   = 12;
  localparam int DEF  = 256;
  localparam int STEP = 16;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [GW-1:0] cfg_gain_r = '0;
  logic [GW-1:0] cfg_gain_b = '0;
  logic          in_vsync = 1'b0;
  logic [GW-1:0] gain_r;
  logic [GW-1:0] gain_b;
  logic          upd_done;
  logic [7:0]    frm_cnt;

  int tests = 0;
  int failures = 0;

  // Model state: active and requested gains, whether a request is outstanding, frame count.
  int mGainR, mGainB, mTgtR, mTgtB, mFrm;
  bit mBusy, mDone, mPrevVs;

  isp_wb_ctrl #(.GAIN_W(GW), .DEF_GAIN(DEF), .RAMP_STEP(STEP)) dut (
    .pclk(pclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_gain_r(cfg_gain_r), .cfg_gain_b(cfg_gain_b), .in_vsync(in_vsync),
    .gain_r(gain_r), .gain_b(gain_b), .upd_done(upd_done), .frm_cnt(frm_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int moveToward(input int cur, input int tgt);
`ifdef WB_GAIN_RAMP_EN
    int diff = tgt - cur;
    if (diff >= -STEP && diff <= STEP) return tgt;
    return (diff > 0) ? cur + STEP : cur - STEP;
`else
    return (cur == cur) ? tgt : tgt;
`endif
  endfunction

  task automatic modelReset();
    mGainR = DEF; mGainB = DEF; mTgtR = DEF; mTgtB = DEF;
    mFrm = 0; mBusy = 0; mDone = 0; mPrevVs = 0;
  endtask

  task automatic modelStep(input bit vs, input bit valid, input int r, input int b);
    bit rise = vs && !mPrevVs;
    bit wasBusy = mBusy;
    mPrevVs = vs;
    mDone = 0;
    if (rise && wasBusy) begin
      mGainR = moveToward(mGainR, mTgtR);
      mGainB = moveToward(mGainB, mTgtB);
      if (mGainR == mTgtR && mGainB == mTgtB) begin
        mDone = 1;
        mBusy = 0;
      end
    end
    if (mDone) mFrm = 0;
    else if (rise) mFrm = (mFrm < 255) ? mFrm + 1 : 255;
    if (valid && !wasBusy) begin
      mTgtR = r; mTgtB = b; mBusy = 1;
    end
  endtask

  task automatic checkOutput();
    checkOne("gain_r", gain_r, mGainR);
    checkOne("gain_b", gain_b, mGainB);
    checkOne("upd_done", upd_done, mDone);
    checkOne("frm_cnt", frm_cnt, mFrm);
    checkOne("cfg_ready", cfg_ready, !mBusy);
  endtask

  // Called at posedge+1: drive inputs, let one edge pass, then compare against the model.
  task automatic applyStimulus(input bit vs, input bit valid, input int r, input int b);
    in_vsync = vs; cfg_valid = valid;
    cfg_gain_r = GW'(r); cfg_gain_b = GW'(b);
    checkOne("cfg_ready_pre", cfg_ready, !mBusy);
    @(posedge pclk);
    modelStep(vs, valid, r, b);
    #1;
    checkOutput();
  endtask

  task automatic frame(input bit valid, input int r, input int b);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, valid, r, b);
  endtask

  function automatic int randGain();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return 0;
    if (sel == 1) return 4095;
    return $urandom_range(0, 4095);
  endfunction

  initial begin
    modelReset();
    repeat (3) @(posedge pclk);
    #1;
    checkOne("rst_gain_r", gain_r, DEF);
    checkOne("rst_gain_b", gain_b, DEF);
    checkOne("rst_upd_done", upd_done, 0);
    checkOne("rst_frm_cnt", frm_cnt, 0);
    rst = 1'b0;
    #1;
    checkOne("rst_cfg_ready", cfg_ready, 1);

    // Idle frames, enough to saturate the frame counter.
    for (int i = 0; i < 260; i++) frame(0, 0, 0);
    checkOne("frm_sat", frm_cnt, 255);

    // Mid-frame transfer waits for the next boundary.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 400, 300);
    checkOne("mid_hold_r", gain_r, DEF);
    checkOne("mid_ready", cfg_ready, 0);
`ifndef WB_GAIN_RAMP_EN
    frame(0, 0, 0);
    checkOne("apply_r", gain_r, 400);
    checkOne("apply_b", gain_b, 300);
    checkOne("apply_done", upd_done, 1);
    checkOne("apply_frm", frm_cnt, 0);
    applyStimulus(1, 0, 0, 0);
    checkOne("done_pulse", upd_done, 0);

    // Transfer on the boundary cycle; a second offer while pending is refused.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 1000, 50);
    checkOne("coinc_hold_r", gain_r, 400);
    applyStimulus(1, 1, 7, 7);
    frame(0, 0, 0);
    checkOne("coinc_apply_r", gain_r, 1000);
    checkOne("coinc_apply_b", gain_b, 50);
`else
    for (int i = 0; i < 20 && mBusy; i++) frame(0, 0, 0);
    // Ramp from the default toward 300/200.
    begin
      int expR[4] = '{272, 288, 300, 300};
      int expB[4] = '{240, 224, 208, 200};
      rst = 1'b1; #1; rst = 1'b0; modelReset(); in_vsync = 0;
      applyStimulus(0, 1, 300, 200);
      for (int i = 0; i < 4; i++) begin
        frame(0, 0, 0);
        checkOne("ramp_r", gain_r, expR[i]);
        checkOne("ramp_b", gain_b, expB[i]);
        checkOne("ramp_done", upd_done, (i == 3));
      end
    end
`endif

    // Extreme gain values are accepted unclamped.
    applyStimulus(1, 1, 0, 4095);
    for (int i = 0; i < 300 && mBusy; i++) frame(0, 0, 0);
    checkOne("edge_settle", mBusy, 0);
    checkOne("edge_r0", gain_r, 0);
    checkOne("edge_b4095", gain_b, 4095);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bit vs = ($urandom_range(0, 3) == 0) ? !in_vsync : in_vsync;
      applyStimulus(vs, $urandom_range(0, 1), randGain(), randGain());
    end

    // Asynchronous reset while a request is pending discards it.
    for (int i = 0; i < 300 && mBusy; i++) frame(0, 0, 0);
    applyStimulus(1, 1, 900, 800);
    frame(0, 0, 0);
    applyStimulus(1, 1, 123, 456);
    checkOne("pend_ready", cfg_ready, 0);
    #2 rst = 1'b1;
    #1;
    checkOne("arst_gain_r", gain_r, DEF);
    checkOne("arst_gain_b", gain_b, DEF);
    checkOne("arst_ready", cfg_ready, 1);
    checkOne("arst_frm", frm_cnt, 0);
    in_vsync = 0; cfg_valid = 0;
    @(posedge pclk);
    #1 rst = 1'b0;
    modelReset();
    frame(0, 0, 0);
    frame(0, 0, 0);
    checkOne("lost_tgt_r", gain_r, DEF);
    checkOne("lost_tgt_b", gain_b, DEF);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/isp_wb_ctrl.md
ISP_WB_CTRL -- requirements
Module: isp_wb_ctrl

Interface
REQ-001 The block SHALL have parameter GAIN_W, default 12, meaning the gain width in unsigned 4.8 fixed point.
REQ-002 The block SHALL have parameter DEF_GAIN, default 256, meaning the power-on gain of 1.0 for both channels.
REQ-003 The block SHALL have parameter RAMP_STEP, default 16, meaning the maximum per-frame gain change when ramping.
REQ-004 pclk  input  1  pixel clock; all logic SHALL be clocked on the rising edge of pclk.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 cfg_valid  input  1  the host offers a new gain pair.
REQ-007 cfg_ready  output  1  the block accepts an offer.
REQ-008 cfg_gain_r, cfg_gain_b  input  GAIN_W each  requested gains.
REQ-009 in_vsync  input  1  frame sync; a rising edge marks a frame boundary.
REQ-010 gain_r, gain_b  output  GAIN_W each  active gains driving the white-balance datapath.
REQ-011 upd_done  output  1  one-cycle pulse when the requested gains are fully active.
REQ-012 frm_cnt  output  8  frame boundaries seen since the last upd_done.

Function
REQ-013 A transfer SHALL occur on any cycle where cfg_valid and cfg_ready are both high; the block SHALL capture cfg_gain_r and cfg_gain_b into target registers on that cycle.
REQ-014 States SHALL be IDLE, PEND and RAMP; cfg_ready SHALL be high only in IDLE.
REQ-015 Transitions: IDLE to PEND on a transfer; PEND on a frame boundary to either IDLE or RAMP (see Configuration); RAMP to IDLE when both active gains equal their targets.
REQ-016 The frame boundary signal vs_rise SHALL be in_vsync AND NOT vs_q, where vs_q is in_vsync registered one cycle.
REQ-017 The active gains SHALL change only on cycles where vs_rise is high; they SHALL never change mid-frame.
REQ-018 Latency: the new gain_r/gain_b values and upd_done SHALL be visible in the cycle after the vs_rise cycle.
REQ-019 If a transfer and vs_rise occur in the same cycle while in IDLE, the block SHALL only capture the targets; they SHALL apply at the next vs_rise.
REQ-020 While not in IDLE, cfg_valid SHALL be ignored and the targets SHALL stay unchanged.
REQ-021 frm_cnt SHALL increment on each vs_rise, saturate at 255, and clear to 0 in the cycle upd_done is asserted.
REQ-022 Gains of 0 and 4095 SHALL be legal, with no clamping on input.

Reset
REQ-023 On rst, every sequential element SHALL reset asynchronously, and the block SHALL reset mid-operation with pending targets discarded.
REQ-024 Reset values: state=IDLE, gain_r=gain_b=DEF_GAIN, targets=DEF_GAIN, vs_q=0, upd_done=0, frm_cnt=0.
REQ-025 Output reset values: cfg_ready=1 once rst deasserts.

Configuration
REQ-026 When WB_GAIN_RAMP_EN is defined, PEND SHALL go to RAMP at vs_rise and apply the first step on that same vs_rise.
REQ-027 With WB_GAIN_RAMP_EN defined, on each RAMP step each active gain SHALL move toward its target by min(|target-active|, RAMP_STEP), without overshoot or wrap.
REQ-028 With WB_GAIN_RAMP_EN defined, upd_done SHALL pulse in the cycle after the vs_rise whose step makes both gains equal their targets, and the state SHALL then return to IDLE.
REQ-029 When WB_GAIN_RAMP_EN is undefined, PEND SHALL go to IDLE at vs_rise, load both targets in one step, and contain no RAMP state logic.

Verification
REQ-030 Reset then idle: gain_r=gain_b=256, cfg_ready=1, upd_done=0, and frm_cnt counts vs_rise events, saturating at 255.
REQ-031 Without the macro, transfer r=400, b=300 mid-frame -> gains stay 256 until the next vs_rise, then read 400/300 one cycle later with upd_done=1 for one cycle and frm_cnt=0.
REQ-032 Transfer coincident with vs_rise -> gains unchanged at that boundary and applied at the following boundary; a second cfg_valid while in PEND is not accepted (cfg_ready=0).
REQ-033 With the macro, RAMP_STEP=16, target r=300, b=200 from 256 -> per-frame r: 272, 288, 300 and b: 240, 224, 208, 200, with upd_done only after the 4th boundary.
REQ-034 Assert rst in PEND or RAMP -> gains immediately return to 256, state=IDLE and the pending targets are lost.
